// File: rtl/cam_pkg.sv
// Shared types and constants for the camera register-table sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_SCCB,
    DELAY,
    DONE
  } cam_state_t;

  // Reserved ROM words: end-of-table and settle-delay markers.
  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  // Highest table index; an entry here is always the last one executed.
  localparam logic [7:0] ROM_LAST_ADDR = 8'hFF;

  // Settle-delay length in clock cycles.
  function automatic int unsigned delay_cycles(input int unsigned clk_f,
                                               input int unsigned ms);
    return clk_f / 1000 * ms;
  endfunction

endpackage

// File: rtl/cam_config.sv
// Walks a register-table ROM and issues one SCCB write per entry, with
// settle-delay and end-of-table markers. Latency: 2 cycles from start/next
// entry to decode (address + 1-cycle ROM read); SEND->start is combinational.
// Backpressure: holds in SEND until i_sccb_ready, then waits for the SCCB
// master to return to idle before fetching the next entry.
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_start                request to run (accepted only in IDLE / DONE)
//   o_rom_addr/i_rom_data  ROM address out, {reg_addr, reg_data} back next cycle
//   o_sccb_start/addr/data one-cycle write request with its register payload
//   i_sccb_ready           SCCB master idle
//   o_done                 table finished, held until the next start
module cam_config
  import cam_pkg::*;
#(
  parameter int unsigned CLK_F    = 100_000_000,
  parameter int unsigned DELAY_MS = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_start,
  output logic [7:0]  o_sccb_addr,
  output logic [7:0]  o_sccb_data,
  input  logic        i_sccb_ready,
  output logic        o_done
);

  localparam int unsigned DLY_CYC = delay_cycles(CLK_F, DELAY_MS);
  localparam int unsigned CNT_W   = $clog2(DLY_CYC + 1);
  // Counter runs DLY_CYC-1 down to 0 inclusive, giving DLY_CYC cycles in DELAY.
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DLY_CYC - 1);

  cam_state_t       state, state_nxt;
  logic [CNT_W-1:0] dly_cnt, dly_cnt_nxt;
  logic [7:0]       rom_addr_nxt;
  logic [7:0]       sccb_addr_nxt, sccb_data_nxt;
  logic             done_nxt;
  // Set once the first WAIT_SCCB cycle has elapsed; the master may not have
  // dropped ready yet in that cycle, so it is not trusted there.
  logic             wait_armed, wait_armed_nxt;
  logic             advance;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      o_rom_addr  <= '0;
      o_sccb_addr <= '0;
      o_sccb_data <= '0;
      o_done      <= 1'b0;
      dly_cnt     <= '0;
      wait_armed  <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_rom_addr  <= rom_addr_nxt;
      o_sccb_addr <= sccb_addr_nxt;
      o_sccb_data <= sccb_data_nxt;
      o_done      <= done_nxt;
      dly_cnt     <= dly_cnt_nxt;
      wait_armed  <= wait_armed_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rom_addr_nxt   = o_rom_addr;
    sccb_addr_nxt  = o_sccb_addr;
    sccb_data_nxt  = o_sccb_data;
    dly_cnt_nxt    = dly_cnt;
    wait_armed_nxt = wait_armed;
    o_sccb_start   = 1'b0;
    advance        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          rom_addr_nxt = '0;
          state_nxt    = FETCH;
        end
      end
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (i_rom_data == ROM_END) begin
          state_nxt = DONE;
        end else if (i_rom_data == ROM_DELAY) begin
          dly_cnt_nxt = DLY_LOAD;
          state_nxt   = DELAY;
        end else begin
          sccb_addr_nxt = i_rom_data[15:8];
          sccb_data_nxt = i_rom_data[7:0];
          state_nxt     = SEND;
        end
      end
      SEND: begin
        // Start is gated by ready in the same cycle so it can never be lost.
        if (i_sccb_ready) begin
          o_sccb_start   = 1'b1;
          wait_armed_nxt = 1'b0;
          state_nxt      = WAIT_SCCB;
        end
      end
      WAIT_SCCB: begin
        if (!wait_armed) begin
          wait_armed_nxt = 1'b1;
        end else if (i_sccb_ready) begin
          advance = 1'b1;
        end
      end
      DELAY: begin
        if (dly_cnt == '0) begin
          advance = 1'b1;
        end else begin
          dly_cnt_nxt = dly_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Finishing the entry at the last address ends the table instead of
    // wrapping back to entry 0.
    if (advance) begin
      if (o_rom_addr == ROM_LAST_ADDR) begin
        state_nxt = DONE;
      end else begin
        rom_addr_nxt = o_rom_addr + 8'd1;
        state_nxt    = FETCH;
      end
    end

    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_cam_config.sv
// Self-checking bench for cam_config (CLK_F=1000, DELAY_MS=10 -> 10-cycle delay).
// Latency: n/a.
// Backpressure: i_sccb_ready driven directly or randomly per test.
module tb_cam_config;

  localparam int DLY = 10;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_sccb_ready = 1'b1;
  logic [15:0] i_rom_data;
  logic [7:0]  o_rom_addr, o_sccb_addr, o_sccb_data;
  logic        o_sccb_start, o_done;

  logic [15:0] rom [256];
  wr_t         exp_q[$];
  int          start_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_starts = 0;
  logic        prev_start = 1'b0;

  cam_config #(.CLK_F(1000), .DELAY_MS(10)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data),
    .o_sccb_start (o_sccb_start),
    .o_sccb_addr  (o_sccb_addr),
    .o_sccb_data  (o_sccb_data),
    .i_sccb_ready (i_sccb_ready),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural ROM, one-cycle read latency.
  always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every SCCB write is checked against the head of the scoreboard.
  initial forever begin
    @(negedge i_clk);
    cyc++;
    if (i_rstn !== 1'b1) begin
      prev_start = 1'b0;
    end else begin
      if (o_sccb_start === 1'b1) begin
        n_starts++;
        start_cyc.push_back(cyc);
        chk("start_needs_ready", i_sccb_ready, 1);
        chk("no_back_to_back_start", prev_start, 0);
        chk("write_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("sccb_addr", o_sccb_addr, e.a);
          chk("sccb_data", o_sccb_data, e.d);
        end
      end
      prev_start = o_sccb_start;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic fill_end();
    for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
  endtask

  // Reference model: table walk from entry 0, one write per ordinary word,
  // stopping at the end marker or after the last address.
  task automatic load_expect(output int last);
    last = 255;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) begin
        last = a;
        break;
      end
      if (rom[a] != 16'hFFF0) exp_q.push_back(wr_t'(rom[a]));
    end
  endtask

  task automatic wait_done(input int bound, input int last, input string tag, input bit rnd);
    int n = 0;
    while (o_done !== 1'b1 && n < bound) begin
      if (rnd) i_sccb_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    i_sccb_ready = 1'b1;
    chk({tag, "_done_in_time"}, o_done, 1);
    chk({tag, "_final_addr"}, o_rom_addr, last);
    chk({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (o_sccb_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, o_sccb_start, 1);
  endtask

  initial begin
    int last, ns0, seen;
    fill_end();

    // Reset state
    tick();
    tick();
    chk("rst_rom_addr", o_rom_addr, 0);
    chk("rst_sccb_start", o_sccb_start, 0);
    chk("rst_sccb_addr", o_sccb_addr, 0);
    chk("rst_sccb_data", o_sccb_data, 0);
    chk("rst_done", o_done, 0);
    i_rstn = 1'b1;
    tick();

    // Basic table with a settle delay between two writes.
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    start_cyc.delete();
    load_expect(last);
    pulse_start();
    wait_done(200, last, "t1", 1'b0);
    chk("t1_start_count", start_cyc.size(), 2);
    if (start_cyc.size() == 2)
      chk("t1_start_gap", start_cyc[1] - start_cyc[0], DLY + 7);

    // Master busy for 20 cycles while a write is pending.
    fill_end();
    rom[0] = 16'h3A5C;
    i_sccb_ready = 1'b0;
    load_expect(last);
    ns0 = n_starts;
    pulse_start();
    seen = 0;
    repeat (20) begin
      tick();
      if (o_sccb_start === 1'b1) seen++;
    end
    chk("t2_no_start_while_busy", seen, 0);
    chk("t2_addr_held", o_sccb_addr, 8'h3A);
    chk("t2_data_held", o_sccb_data, 8'h5C);
    i_sccb_ready = 1'b1;
    #1;
    chk("t2_start_on_ready", o_sccb_start, 1);
    wait_done(100, last, "t2", 1'b0);
    chk("t2_single_start", n_starts - ns0, 1);

    // Ready drops right after the start and returns 5 cycles later.
    fill_end();
    rom[0] = 16'h1111; rom[1] = 16'h2222;
    load_expect(last);
    ns0 = n_starts;
    pulse_start();
    wait_start("t3");
    tick();
    i_sccb_ready = 1'b0;
    seen = 0;
    repeat (5) begin
      tick();
      if (o_rom_addr !== 8'd0) seen++;
    end
    chk("t3_addr_held_while_busy", seen, 0);
    i_sccb_ready = 1'b1;
    chk("t3_addr_before_exit", o_rom_addr, 0);
    tick();
    chk("t3_addr_after_exit", o_rom_addr, 1);
    wait_done(100, last, "t3", 1'b0);
    chk("t3_start_count", n_starts - ns0, 2);

    // Reset during the settle delay (counter at 4).
    fill_end();
    rom[0] = 16'hFFF0; rom[1] = 16'h55AA;
    load_expect(last);
    pulse_start();
    repeat (7) tick();
    i_rstn = 1'b0;
    #1;
    chk("t4_rst_rom_addr", o_rom_addr, 0);
    chk("t4_rst_sccb_start", o_sccb_start, 0);
    chk("t4_rst_sccb_addr", o_sccb_addr, 0);
    chk("t4_rst_sccb_data", o_sccb_data, 0);
    chk("t4_rst_done", o_done, 0);
    exp_q.delete();
    ns0 = n_starts;
    repeat (3) tick();
    i_rstn = 1'b1;
    repeat (30) tick();
    chk("t4_no_write_after_abort", n_starts - ns0, 0);
    chk("t4_idle_addr", o_rom_addr, 0);
    load_expect(last);
    pulse_start();
    wait_done(200, last, "t4", 1'b0);

    // Full table with no end marker: 256 writes, no wrap.
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom_range(0, 16'hFFEF));
    load_expect(last);
    ns0 = n_starts;
    pulse_start();
    wait_done(256 * 6 + 50, last, "t5", 1'b0);
    chk("t5_write_count", n_starts - ns0, 256);
    repeat (20) tick();
    chk("t5_done_holds", o_done, 1);
    chk("t5_no_wrap_addr", o_rom_addr, 255);
    chk("t5_no_extra_write", n_starts - ns0, 256);

    // Start ignored while waiting on the master; honoured in DONE.
    fill_end();
    rom[0] = 16'h0A01; rom[1] = 16'h0B02;
    load_expect(last);
    pulse_start();
    wait_start("t6");
    tick();
    pulse_start();
    wait_done(100, last, "t6a", 1'b0);
    load_expect(last);
    pulse_start();
    chk("t6_done_clears", o_done, 0);
    wait_done(100, last, "t6b", 1'b0);

    // Random tables with random master backpressure.
    for (int it = 0; it < 8; it++) begin
      int len;
      fill_end();
      len = $urandom_range(1, 24);
      for (int a = 0; a < len; a++)
        rom[a] = ($urandom_range(0, 99) < 15) ? 16'hFFF0 : 16'($urandom_range(0, 16'hFFEF));
      load_expect(last);
      pulse_start();
      wait_done(3000, last, "rnd", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_config.md
CAM_CONFIG -- requirements
Module: cam_config

Interface
REQ-001 SHALL have parameter CLK_F, default 100_000_000, i_clk frequency in Hz.
REQ-002 SHALL have parameter DELAY_MS, default 10, settle delay in ms executed on the delay marker.
REQ-003 SHALL have port i_clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  level/pulse request to run the configuration sequence.
REQ-006 SHALL have port o_rom_addr  output  8  address to the register-table ROM.
REQ-007 SHALL have port i_rom_data  input  16  ROM word: [15:8] register address, [7:0] register data; one-cycle read latency.
REQ-008 SHALL have port o_sccb_start  output  1  one-cycle write request to the SCCB master.
REQ-009 SHALL have port o_sccb_addr  output  8  register address for the SCCB write.
REQ-010 SHALL have port o_sccb_data  output  8  register data for the SCCB write.
REQ-011 SHALL have port i_sccb_ready  input  1  SCCB master idle, able to accept o_sccb_start.
REQ-012 SHALL have port o_done  output  1  sequence complete, held high until next start.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DECODE, SEND, WAIT_SCCB, DELAY, DONE.
REQ-014 IDLE: on i_start=1 SHALL load o_rom_addr=0 and go to FETCH; otherwise hold.
REQ-015 FETCH SHALL last exactly one cycle (ROM latency), then go to DECODE.
REQ-016 DECODE, i_rom_data=16'hFFFF: SHALL go to DONE.
REQ-017 DECODE, i_rom_data=16'hFFF0: SHALL load delay counter with CLK_F/1000*DELAY_MS-1 and go to DELAY.
REQ-018 DECODE, any other word: SHALL register [15:8] into o_sccb_addr, [7:0] into o_sccb_data, and go to SEND.
REQ-019 SEND: SHALL assert o_sccb_start for exactly one cycle, only in a cycle where i_sccb_ready=1; otherwise wait in SEND with o_sccb_start=0.
REQ-020 WAIT_SCCB: SHALL ignore i_sccb_ready in the first cycle after the start pulse, then wait for i_sccb_ready=1.
REQ-021 WAIT_SCCB and DELAY exit: SHALL increment o_rom_addr and go to FETCH.
REQ-022 DELAY: SHALL decrement the counter each cycle; at zero SHALL exit per REQ-021; total DELAY dwell SHALL be CLK_F/1000*DELAY_MS cycles.
REQ-023 Address wrap: if o_rom_addr=255 and the entry is not FFFF, then after completing that entry the block SHALL go to DONE, not wrap to 0.
REQ-024 o_sccb_addr/o_sccb_data SHALL stay stable from DECODE until the next DECODE.
REQ-025 i_start SHALL be ignored in every state other than IDLE and DONE.
REQ-026 DONE: o_done=1; on i_start=1 SHALL clear o_done, set o_rom_addr=0 and go to FETCH (reconfiguration).
REQ-027 Delay counter width SHALL be $clog2(CLK_F/1000*DELAY_MS+1) bits, no overflow.

Reset
REQ-028 On i_rstn=0, asynchronously: state=IDLE, o_rom_addr=0, o_sccb_start=0, o_sccb_addr=0, o_sccb_data=0, o_done=0, delay counter=0.
REQ-029 Reset mid-sequence (any state) SHALL abort without emitting a further o_sccb_start; the sequence restarts only on a new i_start after release.

Structure
REQ-030 Shared package cam_pkg SHALL hold the FSM state enum and constants ROM_END=16'hFFFF, ROM_DELAY=16'hFFF0.
REQ-031 SHALL be a single module with no sub-modules; the delay counter SHALL be inline.

Verification (CLK_F=1000, DELAY_MS=10 -> 10-cycle delay; behavioural ROM with 1-cycle latency)
REQ-032 ROM {0:12_80, 1:FF_F0, 2:12_04, 3:FF_FF}, ready always 1, start pulse -> writes (12,80) then (12,04); exactly 10 DELAY cycles between them; o_done=1 after addr 3.
REQ-033 i_sccb_ready held 0 for 20 cycles after DECODE -> o_sccb_start stays 0, asserts once in the first cycle ready=1; addr/data unchanged.
REQ-034 Ready dropping 1 cycle after start and returning 5 cycles later -> o_rom_addr increments only after ready returns; no double start.
REQ-035 Reset asserted during DELAY at count 4 -> all outputs 0 immediately; no SCCB write until a new start; a new start replays from addr 0.
REQ-036 ROM with no FFFF in 256 entries -> 256 writes, then o_done=1, o_rom_addr not wrapped to 0 and issued again.
REQ-037 i_start pulsed during WAIT_SCCB -> ignored; in DONE -> o_done clears next cycle and the sequence replays from addr 0.
